// File: rtl/barrel_shift_pipe.sv
// barrel_shift_pipe
//   Pipelined logarithmic barrel shifter / rotator with valid/ready handshake.
//   Stage k applies a shift of 2^k when bit k of the operation's amount is set,
//   so a WIDTH-bit operand needs $clog2(WIDTH) stages and results appear
//   exactly STAGES cycles after acceptance when the output is not stalled.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset; clears every stage
//   in_valid   input operation valid
//   in_ready   block accepts an input this cycle (= not stalled)
//   in_data    operand
//   in_amt     shift/rotate amount, 0..WIDTH-1
//   in_op      00=ROR, 01=ROL, 10=SRL, 11=SRA
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   out_data   result
//   out_zero   registered flag, 1 when out_data == 0
module barrel_shift_pipe #(
    parameter int  WIDTH  = 8,
    localparam int SHW    = $clog2(WIDTH),
    localparam int STAGES = SHW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_amt,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero
);

    // One level of the log shifter: move the operand by a fixed distance s.
    // Right shifts fill with zero (SRL) or the operand's MSB (SRA); since
    // every earlier SRA level preserved the MSB, the fill stays correct
    // across levels.
    function automatic logic [WIDTH-1:0] shift_level(
        input logic [WIDTH-1:0] d,
        input logic [1:0]       op,
        input int               s
    );
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            case (op)
                2'b00:   r[i] = d[(i + s) % WIDTH];
                2'b01:   r[i] = d[(i + WIDTH - s) % WIDTH];
                2'b10:   r[i] = (i + s < WIDTH) ? d[(i + s) % WIDTH] : 1'b0;
                default: r[i] = (i + s < WIDTH) ? d[(i + s) % WIDTH] : d[WIDTH-1];
            endcase
        end
        return r;
    endfunction

    // Stage registers. Stage STAGES-1 is the output register.
    logic [STAGES-1:0] valid_pipe;
    logic [WIDTH-1:0]  data_pipe [STAGES];
    logic [1:0]        op_pipe   [STAGES];
    logic [SHW-1:0]    amt_pipe  [STAGES];
    logic              zero_reg;

    // Inputs seen by each stage and the result of its shift level.
    logic [STAGES-1:0] src_valid;
    logic [WIDTH-1:0]  src_data  [STAGES];
    logic [1:0]        src_op    [STAGES];
    logic [SHW-1:0]    src_amt   [STAGES];
    logic [WIDTH-1:0]  lvl_data  [STAGES];

    logic stall;

    assign stall    = valid_pipe[STAGES-1] & ~out_ready;
    assign in_ready = ~stall;

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                // While stalled the pipeline does not load, so in_valid can
                // feed the first stage directly.
                assign src_valid[gi] = in_valid;
                assign src_data[gi]  = in_data;
                assign src_op[gi]    = in_op;
                assign src_amt[gi]   = in_amt;
            end else begin : g_next
                assign src_valid[gi] = valid_pipe[gi-1];
                assign src_data[gi]  = data_pipe[gi-1];
                assign src_op[gi]    = op_pipe[gi-1];
                assign src_amt[gi]   = amt_pipe[gi-1];
            end

            assign lvl_data[gi] = src_amt[gi][gi]
                                ? shift_level(src_data[gi], src_op[gi], 1 << gi)
                                : src_data[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_pipe <= '0;
            zero_reg   <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                data_pipe[k] <= '0;
                op_pipe[k]   <= '0;
                amt_pipe[k]  <= '0;
            end
        end else if (!stall) begin
            // Bubbles advance like real operations (no compression), but a
            // bubble does not overwrite payload, so the output register keeps
            // its last result while out_valid is low.
            valid_pipe <= src_valid;
            for (int k = 0; k < STAGES; k++) begin
                if (src_valid[k]) begin
                    data_pipe[k] <= lvl_data[k];
                    op_pipe[k]   <= src_op[k];
                    amt_pipe[k]  <= src_amt[k];
                end
            end
            if (src_valid[STAGES-1]) begin
                zero_reg <= (lvl_data[STAGES-1] == '0);
            end
        end
    end

    assign out_valid = valid_pipe[STAGES-1];
    assign out_data  = data_pipe[STAGES-1];
    assign out_zero  = zero_reg;

endmodule

// File: tb/tb_barrel_shift_pipe.sv
module tb_barrel_shift_pipe;

    localparam int WIDTH = 8;
    localparam int SHW   = 3;
    localparam int LAT   = 3;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   in_amt;
    logic [1:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_zero;

    barrel_shift_pipe #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_amt   (in_amt),
        .in_op    (in_op),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_zero (out_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Scoreboard: expected result and the cycle the operation was accepted.
    logic [7:0] exp_q [$];
    int         cyc_q [$];

    int         cyc        = 0;
    logic [7:0] pend_exp   = '0;
    logic       acc        = 1'b0;
    logic       lat_on     = 1'b0;
    logic       consec_on  = 1'b0;
    logic       rand_mode  = 1'b0;
    int         stall_cnt  = 0;
    int         npop       = 0;
    int         last_pop   = 0;
    logic       was_stalled = 1'b0;
    logic [7:0] held_data  = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: shift/rotate of an 8-bit value by plain integer arithmetic.
    function automatic logic [7:0] ref_model(input logic [7:0] d, input int n, input logic [1:0] op);
        int v;
        int sv;
        int r;
        v  = int'(d);
        sv = d[7] ? v - 256 : v;
        case (op)
            2'b00:   r = ((v >> n) | (v << (8 - n))) & 255;
            2'b01:   r = ((v << n) | (v >> (8 - n))) & 255;
            2'b10:   r = v >> n;
            default: r = (sv >>> n) & 255;
        endcase
        return r[7:0];
    endfunction

    // One clock: observe transfers at the falling edge, then move past the
    // rising edge and update out_ready for the next cycle.
    task automatic step();
        logic [7:0] e;
        int         c;
        @(negedge clk);
        acc = 1'b0;
        if (!rst) begin
            acc = in_valid && in_ready;
            if (out_valid && !out_ready) begin
                chk("stall_in_ready", in_ready, 0);
                if (was_stalled) chk("stall_hold", out_data, held_data);
                was_stalled = 1'b1;
                held_data   = out_data;
            end else begin
                was_stalled = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", out_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    c = cyc_q.pop_front();
                    $display("OUT cyc=%0d data=0x%02h zero=%0d exp=0x%02h", cyc, out_data, out_zero, e);
                    chk("out_data", out_data, e);
                    chk("out_zero", out_zero, (e == 8'h00));
                    if (lat_on) chk("latency", cyc - c, LAT);
                    if (consec_on && npop > 0) chk("consecutive", cyc - last_pop, 1);
                    last_pop = cyc;
                    npop++;
                end
            end
            if (acc) begin
                exp_q.push_back(pend_exp);
                cyc_q.push_back(cyc);
            end
        end else begin
            was_stalled = 1'b0;
        end
        cyc++;
        @(posedge clk);
        #1;
        if (stall_cnt > 0) begin
            out_ready = 1'b0;
            stall_cnt--;
        end else if (rand_mode) begin
            out_ready = ($urandom_range(0, 3) != 0);
        end else begin
            out_ready = 1'b1;
        end
    endtask

    task automatic send(input logic [7:0] d, input int n, input logic [1:0] op, input logic [7:0] e);
        int tries;
        in_data  = d;
        in_amt   = n[SHW-1:0];
        in_op    = op;
        in_valid = 1'b1;
        pend_exp = e;
        tries    = 0;
        do begin
            step();
            tries++;
        end while (!acc && tries < 50);
        if (!acc) chk("accept_timeout", in_ready, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            step();
            n++;
        end
        chk("drain_left", exp_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        int         n;
        logic [1:0] op;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_amt    = '0;
        in_op     = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset / idle state.
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 8'h00);
        chk("rst_out_zero", out_zero, 0);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        repeat (3) step();
        chk("idle_out_valid", out_valid, 0);

        // Basic vectors, each op on 0xB1 by 3, then boundaries.
        lat_on = 1'b1;
        send(8'hB1, 3, 2'b00, 8'h36);
        send(8'hB1, 3, 2'b01, 8'h8D);
        send(8'hB1, 3, 2'b10, 8'h16);
        send(8'hB1, 3, 2'b11, 8'hF6);
        send(8'h80, 7, 2'b10, 8'h01);
        send(8'h80, 7, 2'b11, 8'hFF);
        send(8'h80, 7, 2'b01, 8'h40);
        send(8'h80, 7, 2'b00, 8'h01);
        for (int k = 0; k < 4; k++) send(8'hB1, 0, k[1:0], 8'hB1);
        send(8'h01, 1, 2'b10, 8'h00);
        drain();

        // Back-to-back streaming: ROR of 0x01 by 0..7.
        consec_on = 1'b1;
        npop      = 0;
        for (int k = 0; k < 8; k++) begin
            d = (k == 0) ? 8'h01 : 8'(1 << (8 - k));
            send(8'h01, k, 2'b00, d);
        end
        drain();
        chk("stream_count", npop, 8);
        consec_on = 1'b0;

        // Backpressure: drop out_ready for four cycles mid-stream.
        lat_on = 1'b0;
        for (int k = 0; k < 5; k++) begin
            d = 8'($urandom);
            n = $urandom_range(0, 7);
            op = 2'($urandom);
            send(d, n, op, ref_model(d, n, op));
            if (k == 1) begin
                out_ready = 1'b0;
                stall_cnt = 3;
            end
        end
        drain();

        // Reset with three operations in flight.
        for (int k = 0; k < 3; k++) send(8'hF0 + 8'(k), 1, 2'b00, 8'h00);
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete();
        cyc_q.delete();
        for (int k = 0; k < 6; k++) begin
            step();
            chk("rst_flush", out_valid, 0);
        end

        // Randomised traffic with random gaps and random back-pressure.
        rand_mode = 1'b1;
        for (int k = 0; k < 200; k++) begin
            repeat ($urandom_range(0, 2)) step();
            d  = 8'($urandom);
            n  = $urandom_range(0, 7);
            op = 2'($urandom);
            if ($urandom_range(0, 7) == 0) d = 8'h00;
            send(d, n, op, ref_model(d, n, op));
        end
        rand_mode = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
